// File: rtl/des_arbiter.sv
// des_arbiter: round-robin arbiter feeding two requesters' 64-bit blocks to a DES engine in two 32-bit halves.
module des_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  input  logic [64:1]  req_data_0,
  input  logic [64:1]  req_data_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  output logic         res_valid_0,
  output logic         res_valid_1,
  output logic [64:1]  res_data,
  output logic         err_timeout,
  output logic         busy,
  output logic         grant_id,
  output logic [32:1]  eng_msg,
  output logic         eng_ready_part1,
  output logic         eng_ready_part2,
  input  logic         eng_read_part1,
  input  logic         eng_done,
  input  logic [64:1]  eng_enc_msg
);
  typedef enum logic [1:0] {IDLE, SEND1, SEND2, RESP} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [64:1] r_buf, r_res;
  logic        r_rdy0, r_rdy1, r_rv0, r_rv1, r_err, r_busy, r_gid, r_pri1, r_erp1, r_erp2;
  logic        w_g, w_to;
  // r_pri1 set means requester 1 wins a tie; cleared by reset so requester 0 starts with priority
  assign w_g  = (req_valid_0 && req_valid_1) ? r_pri1 : req_valid_1;
  assign w_to = (r_cnt == 8'(TIMEOUT_CYCLES - 1)) &&
                ((r_state == SEND1 && !eng_read_part1) || (r_state == SEND2 && !eng_done));
  assign eng_msg         = (r_state == SEND2) ? r_buf[32:1] : r_buf[64:33];
  assign req_ready_0     = r_rdy0;
  assign req_ready_1     = r_rdy1;
  assign res_valid_0     = r_rv0;
  assign res_valid_1     = r_rv1;
  assign res_data        = r_res;
  assign err_timeout     = r_err;
  assign busy            = r_busy;
  assign grant_id        = r_gid;
  assign eng_ready_part1 = r_erp1;
  assign eng_ready_part2 = r_erp2;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_res   <= '0;
      r_rdy0  <= 1'b0;
      r_rdy1  <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_gid   <= 1'b0;
      r_pri1  <= 1'b0;
      r_erp1  <= 1'b0;
      r_erp2  <= 1'b0;
    end else begin
      r_rdy0 <= 1'b0;
      r_rdy1 <= 1'b0;
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      r_err  <= 1'b0;
      r_cnt  <= r_cnt + 8'd1;
      if (w_to) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_err   <= 1'b1;
        r_erp1  <= 1'b0;
        r_erp2  <= 1'b0;
        r_busy  <= 1'b0;
        r_pri1  <= !r_gid;
      end else if (r_state == IDLE) begin
        r_cnt <= '0;
        if (req_valid_0 || req_valid_1) begin
          r_state <= SEND1;
          r_rdy0  <= !w_g;
          r_rdy1  <= w_g;
          r_buf   <= w_g ? req_data_1 : req_data_0;
          r_gid   <= w_g;
          r_busy  <= 1'b1;
          r_erp1  <= 1'b1;
        end
      end else if (r_state == SEND1 && eng_read_part1) begin
        r_state <= SEND2;
        r_cnt   <= '0;
        r_erp1  <= 1'b0;
        r_erp2  <= 1'b1;
      end else if (r_state == SEND2 && eng_done) begin
        r_state <= RESP;
        r_cnt   <= '0;
        r_res   <= eng_enc_msg;
        r_erp2  <= 1'b0;
      end else if (r_state == RESP) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_rv0   <= !r_gid;
        r_rv1   <= r_gid;
        r_pri1  <= !r_gid;
        r_busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_des_arbiter.sv
// tb_des_arbiter: randomized requesters and engine against a transaction-level round-robin model.
module tb_des_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic [64:1] req_data_0 = '0, req_data_1 = '0;
  logic        req_ready_0, req_ready_1, res_valid_0, res_valid_1;
  logic [64:1] res_data;
  logic        err_timeout, busy, grant_id;
  logic [32:1] eng_msg;
  logic        eng_ready_part1, eng_ready_part2;
  logic        eng_read_part1 = 1'b0, eng_done = 1'b0;
  logic [64:1] eng_enc_msg = '0;
  int          n_chk = 0, n_err = 0;
  int          last_g = -1;
  logic [63:0] exp_res = '0;

  des_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .res_valid_0(res_valid_0), .res_valid_1(res_valid_1),
    .res_data(res_data), .err_timeout(err_timeout), .busy(busy), .grant_id(grant_id),
    .eng_msg(eng_msg), .eng_ready_part1(eng_ready_part1), .eng_ready_part2(eng_ready_part2),
    .eng_read_part1(eng_read_part1), .eng_done(eng_done), .eng_enc_msg(eng_enc_msg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready0"}, 64'(req_ready_0), 64'd0);
    check({tag, " ready1"}, 64'(req_ready_1), 64'd0);
    check({tag, " rv0"}, 64'(res_valid_0), 64'd0);
    check({tag, " rv1"}, 64'(res_valid_1), 64'd0);
    check({tag, " err"}, 64'(err_timeout), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " gid"}, 64'(grant_id), 64'd0);
    check({tag, " p1"}, 64'(eng_ready_part1), 64'd0);
    check({tag, " p2"}, 64'(eng_ready_part2), 64'd0);
    check({tag, " res"}, 64'(res_data), 64'd0);
    check({tag, " msg"}, 64'(eng_msg), 64'd0);
  endtask

  // mode: 0 normal, 1 timeout in SEND1, 2 timeout in SEND2, 3 reset during SEND2
  task automatic op(input bit v0, input bit v1, input logic [63:0] dat0, input logic [63:0] dat1,
                    input int d1, input int d2, input bit stale, input int mode);
    int          g;
    logic [63:0] gd, enc;
    enc = {$urandom, $urandom};
    g   = (v0 && v1) ? (last_g < 0 ? 0 : 1 - last_g) : (v1 ? 1 : 0);
    gd  = g ? dat1 : dat0;
    req_valid_0 = v0; req_valid_1 = v1; req_data_0 = dat0; req_data_1 = dat1;
    tick();
    check("grant ready0", 64'(req_ready_0), 64'(g == 0));
    check("grant ready1", 64'(req_ready_1), 64'(g == 1));
    check("grant id", 64'(grant_id), 64'(g));
    check("grant busy", 64'(busy), 64'd1);
    check("send1 p1", 64'(eng_ready_part1), 64'd1);
    check("send1 msg", 64'(eng_msg), 64'(gd[63:32]));
    if (mode == 1) d1 = 63;
    for (int k = 0; k < d1; k++) begin
      eng_done = stale;
      tick();
      check("wait1 p1", 64'(eng_ready_part1), 64'd1);
      check("wait1 p2", 64'(eng_ready_part2), 64'd0);
      check("wait1 msg", 64'(eng_msg), 64'(gd[63:32]));
      check("wait1 rdy", 64'({req_ready_0, req_ready_1}), 64'd0);
      check("wait1 rv", 64'({res_valid_0, res_valid_1, err_timeout}), 64'd0);
    end
    eng_done = stale;
    if (mode == 1) begin
      tick();
      eng_done = 1'b0;
      check("to1 err", 64'(err_timeout), 64'd1);
      check("to1 busy", 64'(busy), 64'd0);
      check("to1 p1", 64'(eng_ready_part1), 64'd0);
      check("to1 res", 64'(res_data), exp_res);
      check("to1 rv", 64'({res_valid_0, res_valid_1}), 64'd0);
      last_g = g;
      return;
    end
    eng_read_part1 = 1'b1;
    tick();
    eng_read_part1 = 1'b0;
    eng_done = 1'b0;
    check("send2 p1", 64'(eng_ready_part1), 64'd0);
    check("send2 p2", 64'(eng_ready_part2), 64'd1);
    check("send2 msg", 64'(eng_msg), 64'(gd[31:0]));
    check("send2 busy", 64'(busy), 64'd1);
    if (mode == 3) begin
      rst = 1'b0;
      tick();
      check_idle_outputs("midrst");
      rst = 1'b1;
      last_g = -1;
      return;
    end
    if (mode == 2) d2 = 63;
    for (int k = 0; k < d2; k++) begin
      tick();
      check("wait2 p2", 64'(eng_ready_part2), 64'd1);
      check("wait2 msg", 64'(eng_msg), 64'(gd[31:0]));
      check("wait2 rv", 64'({res_valid_0, res_valid_1, err_timeout}), 64'd0);
    end
    if (mode == 2) begin
      tick();
      check("to2 err", 64'(err_timeout), 64'd1);
      check("to2 busy", 64'(busy), 64'd0);
      check("to2 p2", 64'(eng_ready_part2), 64'd0);
      check("to2 res", 64'(res_data), exp_res);
      check("to2 rv", 64'({res_valid_0, res_valid_1}), 64'd0);
      last_g = g;
      return;
    end
    eng_done = 1'b1;
    eng_enc_msg = enc;
    tick();
    eng_done = 1'b0;
    eng_enc_msg = ~enc;
    check("resp res", 64'(res_data), enc);
    check("resp rv", 64'({res_valid_0, res_valid_1}), 64'd0);
    check("resp p2", 64'(eng_ready_part2), 64'd0);
    check("resp busy", 64'(busy), 64'd1);
    tick();
    check("done rv0", 64'(res_valid_0), 64'(g == 0));
    check("done rv1", 64'(res_valid_1), 64'(g == 1));
    check("done busy", 64'(busy), 64'd0);
    check("done err", 64'(err_timeout), 64'd0);
    check("done res", 64'(res_data), enc);
    exp_res = enc;
    last_g = g;
  endtask

  initial begin
    int v, mode;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    op(1'b1, 1'b0, 64'h0123456789ABCDEF, 64'h0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      op(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1'b0, 0);
    op(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5, 7, 1'b0, 0);
    op(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 3, 2, 1'b1, 0);
    op(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1'b0, 1);
    op(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1'b0, 2);
    for (int i = 0; i < 40; i++) begin
      v    = $urandom_range(1, 3);
      mode = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      op(v[0], v[1], {$urandom, $urandom}, {$urandom, $urandom},
         $urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom_range(0, 1)), mode);
    end
    op(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 1'b0, 0);
    op(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 1'b0, 3);
    op(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1'b0, 0);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    tick();
    check("final busy", 64'(busy), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
